// File: rtl/deriv_sequencer_if.sv
// Term-entry and result streams of deriv_sequencer, grouped as one bundle.
// The sequencer takes the slave modport; the producer/consumer side takes master.
interface deriv_sequencer_if #(
    parameter int unsigned CW = 4,
    parameter int unsigned EW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [CW-1:0]   in_coef;
    logic [EW-1:0]   in_exp;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [CW+EW-1:0] out_coef;
    logic [EW-1:0]   out_exp;
    logic            out_last;
    logic            busy;
    logic            trunc;

    modport master (
        output in_valid, in_coef, in_exp, in_last, out_ready,
        input  in_ready, out_valid, out_coef, out_exp, out_last, busy, trunc
    );

    modport slave (
        input  in_valid, in_coef, in_exp, in_last, out_ready,
        output in_ready, out_valid, out_coef, out_exp, out_last, busy, trunc
    );
endinterface

// File: rtl/deriv_sequencer.sv
// Power-rule sequencer: buffers up to MAX_TERMS terms, emits (coef*exp, exp-1) in order.
// Optional macro CONST_DROP_EN: constant terms are skipped instead of emitted as (0,0).
module deriv_sequencer #(
    parameter int unsigned MAX_TERMS = 4,
    parameter int unsigned CW        = 4,
    parameter int unsigned EW        = 4
) (
    input logic              clk,
    input logic              rst_n,
    deriv_sequencer_if.slave bus
);
    localparam int unsigned IW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
    localparam int unsigned NW = $clog2(MAX_TERMS + 1);
    localparam int unsigned SW = $clog2(EW + 1);
    localparam int unsigned PW = CW + EW;

    typedef enum logic [1:0] {StLoad, StMul, StEmit} state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   count_q, count_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   step_q, step_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [EW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   out_coef_q, out_coef_d;
    logic [EW-1:0]   out_exp_q, out_exp_d;
    logic            out_last_q, out_last_d;
    logic            trunc_q, trunc_d;
    logic [CW-1:0]   coef_buf_q [MAX_TERMS];
    logic [CW-1:0]   coef_buf_d [MAX_TERMS];
    logic [EW-1:0]   exp_buf_q  [MAX_TERMS];
    logic [EW-1:0]   exp_buf_d  [MAX_TERMS];

    logic            accept;
    logic [CW-1:0]   cur_coef;
    logic [EW-1:0]   cur_exp;
    logic [IW-1:0]   last_emit_idx;
    logic            drop_const;
    logic [PW-1:0]   mul_a;
    logic [EW-1:0]   mul_b;
    logic [PW-1:0]   acc_base;

    assign accept   = (state_q == StLoad) && bus.in_valid;
    assign cur_coef = coef_buf_q[idx_q];
    assign cur_exp  = exp_buf_q[idx_q];

    // Index of the term that carries out_last; with constant dropping this looks
    // ahead past trailing constants, falling back to the final term if all are constant.
    always_comb begin
        last_emit_idx = IW'(count_q - NW'(1));
`ifdef CONST_DROP_EN
        begin
            logic found;
            found = 1'b0;
            for (int unsigned i = 0; i < MAX_TERMS; i++) begin
                if ((NW'(i) < count_q) && (exp_buf_q[i] != '0)) begin
                    last_emit_idx = IW'(i);
                    found         = 1'b1;
                end
            end
            if (!found) begin
                last_emit_idx = IW'(count_q - NW'(1));
            end
        end
`endif
    end

`ifdef CONST_DROP_EN
    assign drop_const = (idx_q != last_emit_idx);
`else
    assign drop_const = 1'b0;
`endif

    // Step 0 takes operands straight from the buffer; later steps use the shift registers.
    assign mul_a    = (step_q == '0) ? PW'(cur_coef) : mcand_q;
    assign mul_b    = (step_q == '0) ? cur_exp : mplier_q;
    assign acc_base = (step_q == '0) ? '0 : acc_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        step_d     = step_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        out_coef_d = out_coef_q;
        out_exp_d  = out_exp_q;
        out_last_d = out_last_q;
        trunc_d    = trunc_q;
        coef_buf_d = coef_buf_q;
        exp_buf_d  = exp_buf_q;

        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    coef_buf_d[IW'(count_q)] = bus.in_coef;
                    exp_buf_d[IW'(count_q)]  = bus.in_exp;
                    count_d                  = count_q + NW'(1);
                    if (count_q == '0) begin
                        trunc_d = 1'b0;
                    end
                    if (bus.in_last || (count_q == NW'(MAX_TERMS - 1))) begin
                        state_d = StMul;
                        idx_d   = '0;
                        step_d  = '0;
                        if (!bus.in_last) begin
                            trunc_d = 1'b1;
                        end
                    end
                end
            end

            StMul: begin
                if (step_q == SW'(EW)) begin
                    // Product is complete; register it for the output stage.
                    out_coef_d = acc_q;
                    out_exp_d  = (cur_exp == '0) ? '0 : cur_exp - EW'(1);
                    out_last_d = (idx_q == last_emit_idx);
                    state_d    = StEmit;
                end else if ((step_q == '0) && (cur_exp == '0)) begin
                    if (drop_const) begin
                        idx_d  = idx_q + IW'(1);
                        step_d = '0;
                    end else begin
                        acc_d  = '0;
                        step_d = SW'(EW);
                    end
                end else begin
                    acc_d    = acc_base + (mul_b[0] ? mul_a : '0);
                    mcand_d  = mul_a << 1;
                    mplier_d = mul_b >> 1;
                    step_d   = step_q + SW'(1);
                end
            end

            StEmit: begin
                if (bus.out_ready) begin
                    if (idx_q == last_emit_idx) begin
                        state_d = StLoad;
                        count_d = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = StMul;
                        idx_d   = idx_q + IW'(1);
                        step_d  = '0;
                    end
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            count_q    <= '0;
            idx_q      <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            out_coef_q <= '0;
            out_exp_q  <= '0;
            out_last_q <= 1'b0;
            trunc_q    <= 1'b0;
            coef_buf_q <= '{default: '0};
            exp_buf_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            out_coef_q <= out_coef_d;
            out_exp_q  <= out_exp_d;
            out_last_q <= out_last_d;
            trunc_q    <= trunc_d;
            coef_buf_q <= coef_buf_d;
            exp_buf_q  <= exp_buf_d;
        end
    end

    assign bus.in_ready  = (state_q == StLoad);
    assign bus.out_valid = (state_q == StEmit);
    assign bus.busy      = (state_q != StLoad);
    assign bus.out_coef  = out_coef_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_last  = out_last_q;
    assign bus.trunc     = trunc_q;
endmodule

// File: tb/tb_deriv_sequencer.sv
// Directed bench for deriv_sequencer: single-term vector table plus multi-term,
// backpressure, truncation, latency and reset-abort sequences.
module tb_deriv_sequencer;
    localparam int unsigned MAX_TERMS = 4;
    localparam int unsigned CW        = 4;
    localparam int unsigned EW        = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    deriv_sequencer_if #(.CW(CW), .EW(EW)) bus ();

    deriv_sequencer #(
        .MAX_TERMS (MAX_TERMS),
        .CW        (CW),
        .EW        (EW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [CW-1:0] coef;
        logic [EW-1:0] exp;
        int unsigned   r_coef;
        int unsigned   r_exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic send_term(input logic [CW-1:0] c, input logic [EW-1:0] e, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=%b, required 1", bus.in_ready);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_coef  = c;
        bus.in_exp   = e;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic recv_term(input string name, input int unsigned c, input int unsigned e,
                             input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.out_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got out_valid=%b, required 1", name, bus.out_valid);
            return;
        end
        check({name, "_coef"}, 32'(bus.out_coef), c);
        check({name, "_exp"}, 32'(bus.out_exp), e);
        check({name, "_last"}, 32'(bus.out_last), 32'(l));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // Expects no result for the given number of cycles and the input side open afterwards.
    task automatic expect_idle(input string name, input int cycles);
        int seen;
        seen = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        bus.out_ready = 1'b0;
        check({name, "_extra_outputs"}, 32'(seen), 0);
        check({name, "_in_ready"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        int first_k;
        n_tests       = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.in_coef   = '0;
        bus.in_exp    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;

        vecs[0] = '{coef: 4'd2,  exp: 4'd3,  r_coef: 6,   r_exp: 2};
        vecs[1] = '{coef: 4'd15, exp: 4'd15, r_coef: 225, r_exp: 14};
        vecs[2] = '{coef: 4'd1,  exp: 4'd1,  r_coef: 1,   r_exp: 0};
        vecs[3] = '{coef: 4'd0,  exp: 4'd5,  r_coef: 0,   r_exp: 4};
        vecs[4] = '{coef: 4'd7,  exp: 4'd8,  r_coef: 56,  r_exp: 7};
        vecs[5] = '{coef: 4'd9,  exp: 4'd0,  r_coef: 0,   r_exp: 0};
        vecs[6] = '{coef: 4'd13, exp: 4'd6,  r_coef: 78,  r_exp: 5};
        vecs[7] = '{coef: 4'd15, exp: 4'd1,  r_coef: 15,  r_exp: 0};

        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_coef", 32'(bus.out_coef), 0);
        check("rst_out_exp", 32'(bus.out_exp), 0);
        check("rst_out_last", 32'(bus.out_last), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_trunc", 32'(bus.trunc), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-term polynomials from the table.
        for (int i = 0; i < 8; i++) begin
            send_term(vecs[i].coef, vecs[i].exp, 1'b1);
            recv_term($sformatf("vec%0d", i), vecs[i].r_coef, vecs[i].r_exp, 1'b1);
        end

        // Mixed polynomial with a trailing constant.
        send_term(4'd3, 4'd2, 1'b0);
        send_term(4'd5, 4'd1, 1'b0);
        send_term(4'd7, 4'd0, 1'b1);
        recv_term("mix0", 6, 1, 1'b0);
`ifdef CONST_DROP_EN
        recv_term("mix1", 5, 0, 1'b1);
`else
        recv_term("mix1", 5, 0, 1'b0);
        recv_term("mix2", 0, 0, 1'b1);
`endif
        expect_idle("mix", 10);

        // All-constant polynomial.
        send_term(4'd4, 4'd0, 1'b0);
        send_term(4'd9, 4'd0, 1'b1);
`ifdef CONST_DROP_EN
        recv_term("const0", 0, 0, 1'b1);
`else
        recv_term("const0", 0, 0, 1'b0);
        recv_term("const1", 0, 0, 1'b1);
`endif
        expect_idle("const", 10);

        // Backpressure: result must hold steady while out_ready stays low.
        send_term(4'd15, 4'd15, 1'b1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i),
                  32'({bus.out_valid, bus.out_last, bus.out_exp, bus.out_coef}),
                  32'({1'b1, 1'b1, 4'd14, 8'd225}));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_out_valid_after", 32'(bus.out_valid), 0);
        check("bp_in_ready_after", 32'(bus.in_ready), 1);

        // Truncation at MAX_TERMS: fifth term offered while busy is refused.
        send_term(4'd1, 4'd1, 1'b0);
        send_term(4'd1, 4'd2, 1'b0);
        send_term(4'd1, 4'd3, 1'b0);
        send_term(4'd1, 4'd4, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_coef  = 4'd1;
        bus.in_exp   = 4'd5;
        bus.in_last  = 1'b0;
        check("tr_in_ready", 32'(bus.in_ready), 0);
        check("tr_trunc", 32'(bus.trunc), 1);
        check("tr_busy", 32'(bus.busy), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        recv_term("tr0", 1, 0, 1'b0);
        recv_term("tr1", 2, 1, 1'b0);
        recv_term("tr2", 3, 2, 1'b0);
        recv_term("tr3", 4, 3, 1'b1);
        @(negedge clk);
        check("tr_trunc_held", 32'(bus.trunc), 1);
        check("tr_in_ready_after", 32'(bus.in_ready), 1);

        // Next accepted term clears trunc; also the latency check.
        send_term(4'd2, 4'd3, 1'b1);
        check("tr_trunc_cleared", 32'(bus.trunc), 0);
        first_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                first_k = k;
                break;
            end
        end
        check("lat_edges", 32'(first_k), 5);
        recv_term("lat", 6, 2, 1'b1);

        // Reset asserted while the second term is being multiplied.
        send_term(4'd3, 4'd2, 1'b0);
        send_term(4'd5, 4'd3, 1'b1);
        recv_term("ra0", 6, 1, 1'b0);
        @(posedge clk);
        #1;
        check("ra_busy_before", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("ra_in_ready", 32'(bus.in_ready), 1);
        check("ra_out_valid", 32'(bus.out_valid), 0);
        check("ra_out_coef", 32'(bus.out_coef), 0);
        check("ra_out_exp", 32'(bus.out_exp), 0);
        check("ra_busy", 32'(bus.busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("ra", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/deriv_sequencer.md
# deriv_sequencer

Sequential controller that applies the power rule to a polynomial, one term at a time. It accepts up to MAX_TERMS (coefficient, exponent) terms over a valid/ready input stream and buffers them. It then computes coef·exp with an iterative shift-add multiplier and decrements the exponent. Results go out on a valid/ready output stream in input order. It sits between the calculator's term-entry logic and the result display path.

## Interface
- MAX_TERMS, 4: term buffer depth (≥1)
- CW, 4: coefficient width
- EW, 4: exponent width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  input term valid
- in_ready  out  1  term buffer can accept
- in_coef  in  CW  unsigned coefficient
- in_exp  in  EW  unsigned exponent
- in_last  in  1  final term of polynomial
- out_valid  out  1  result term valid
- out_ready  in  1  consumer accepts result
- out_coef  out  CW+EW  coef·exp, unsigned
- out_exp  out  EW  exp−1 (0 for constant terms)
- out_last  out  1  final result term
- busy  out  1  high in MUL or EMIT
- trunc  out  1  polynomial was cut at MAX_TERMS

## Operation
- States: LOAD, MUL, EMIT.
- LOAD:
  - in_ready=1; a term is written on in_valid&&in_ready.
  - On acceptance with in_last=1, or of the MAX_TERMS-th term: go to MUL with index 0.
  - Cut at MAX_TERMS with in_last=0: set trunc.
- trunc clears when the first term of the next polynomial is accepted.
- Input terms arriving in MUL/EMIT are not accepted (in_ready=0).
- MUL, term with exp≠0:
  - Shift-add over EW cycles, one exponent bit per cycle, LSB first.
  - Accumulator is CW+EW bits; no overflow is possible (max 15·15=225).
  - out_exp=exp−1.
  - Go to EMIT.
- MUL, term with exp=0: 1 cycle, result (0,0). With CONST_DROP_EN the term is skipped, not emitted (see Configuration).
- EMIT:
  - out_valid=1; out_coef/out_exp/out_last held stable until out_ready.
  - On handshake: if more terms remain, index+1 → MUL; else count cleared → LOAD.
- out_last=1 on the last emitted term only.
- Term count 0 is impossible: LOAD leaves only after accepting a term.

## Timing
- Reset (async, immediate) values:
  - State LOAD, count 0, index 0.
  - in_ready=1, out_valid=0, out_coef=0, out_exp=0, out_last=0, busy=0, trunc=0.
- Reset mid-MUL or mid-EMIT aborts the polynomial; no partial output follows reset release.
- Last input term is accepted at edge T; MUL begins at T+1.
- Non-constant term: out_valid rises EW+1 edges after MUL entry (EW multiply cycles, then registered output).
- Constant term: out_valid rises 2 edges after MUL entry.
- After an EMIT handshake at edge E, the next MUL starts at E+1. No back-to-back out_valid; minimum gap is the MUL length.
- Final handshake at E: in_ready=1 from E+1.
- out_valid never drops without out_ready. Outputs are registered; no combinational in→out path.

## Configuration
- CONST_DROP_EN defined:
  - Terms with exp=0 spend 1 MUL cycle and are not emitted.
  - out_last goes on the last emitted non-constant term. The sequencer looks ahead, so out_last is correct even when trailing terms are constants.
  - If every term is constant, a single (0,0) term is emitted with out_last=1.
- CONST_DROP_EN undefined: every input term produces exactly one output term; constants yield (0,0).

## Test plan
- Terms (3,2),(5,1),(7,0 last), out_ready=1, CONST_DROP_EN defined → (6,1),(5,0,last). Undefined → (6,1),(5,0),(0,0,last).
- Backpressure:
  - Term (15,15 last), out_ready held 0 for 10 cycles → out_valid held with out_coef=225, out_exp=14 stable.
  - Then out_ready=1 → single handshake, in_ready=1 next cycle.
- MAX_TERMS=4, 5 terms (1,1)..(1,5) with no in_last → first 4 accepted, in_ready=0 at the 5th, trunc=1.
  - Outputs (1,0),(2,1),(3,2),(4,3,last).
  - trunc clears on the next accepted term.
- CONST_DROP_EN, terms (4,0),(9,0 last) → exactly one output (0,0,last).
- Assert rst_n=0 mid-MUL of the 2nd term → all outputs at reset values immediately; after release, no output and in_ready=1.
- Latency check, EW=4: single term (2,3 last) accepted at edge T → out_valid first seen after edge T+5, value (6,2,last).
